// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling, framing-error and overrun flags
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shft_q, shft_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick;

  assign tick = (state_q != S_IDLE) && (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = (baud_q != '0) ? baud_q - CW'(1) : baud_q;
    bit_d   = bit_q;
    shft_d  = shft_q;
    data_d  = data_q;
    rdy_d   = rdy_q & ~clr_rdy;
    ovr_d   = ovr_q & ~clr_rdy;
    ferr_d  = ferr_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          baud_d  = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        // A start bit that is gone by mid-bit was a glitch: drop it silently.
        if (tick) begin
          if (!rx_s_q) begin
            baud_d  = FULL_M1;
            bit_d   = 4'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shft_d = {rx_s_q, shft_q[7:1]};
          bit_d  = bit_q + 4'd1;
          baud_d = FULL_M1;
          if (bit_q == 4'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            data_d  = shft_q;
            rdy_d   = 1'b1;
            ferr_d  = 1'b0;
            ovr_d   = ovr_d | rdy_q;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a stuck-low line cannot re-trigger.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shft_q  <= 8'h00;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= RX;
      rx_s_q  <= sync1_q;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shft_q  <= shft_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign frm_err = ferr_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at BAUD_DIV=16
module tb_uart_rx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int edge_cnt;
  int rdy_lat;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
    if (rdy && rdy_lat == 0) rdy_lat = edge_cnt;
  endtask

  task automatic bit_out(input logic v, input int clocks);
    RX = v;
    repeat (clocks) step();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    edge_cnt = 0;
    rdy_lat  = 0;
    bit_out(1'b0, BD);
    for (int i = 0; i < 8; i++) bit_out(d[i], BD);
    bit_out(stop, BD);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    step();
    clr_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    rst     = 1'b1;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rdy", rdy, 1'b0);
    check("reset_frm_err", frm_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    bit_out(1'b1, BD);

    // 0xA5: rdy expected 155 edges after the pin falls (2 sync + 9.5 bits + 1)
    send_byte(8'hA5, 1'b1);
    check("a5_latency_window", (rdy_lat >= 154) && (rdy_lat <= 156), 1'b1);
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_rdy", rdy, 1'b1);
    check("a5_frm_err", frm_err, 1'b0);
    check("a5_overrun", overrun, 1'b0);
    pulse_clr();
    check("a5_clr_rdy", rdy, 1'b0);

    // Back-to-back without acknowledge
    send_byte(8'h00, 1'b1);
    check("b2b_first_data", rx_data, 8'h00);
    send_byte(8'hFF, 1'b1);
    check("b2b_rx_data", rx_data, 8'hFF);
    check("b2b_rdy", rdy, 1'b1);
    check("b2b_overrun", overrun, 1'b1);
    pulse_clr();
    check("b2b_clr_rdy", rdy, 1'b0);
    check("b2b_clr_overrun", overrun, 1'b0);
    bit_out(1'b1, BD);

    // Bad stop bit, then line held low
    send_byte(8'h3C, 1'b0);
    bit_out(1'b0, 40);
    check("ferr_frm_err", frm_err, 1'b1);
    check("ferr_rdy", rdy, 1'b0);
    check("ferr_rx_data", rx_data, 8'hFF);
    bit_out(1'b1, 2 * BD);
    send_byte(8'h5A, 1'b1);
    check("after_ferr_rx_data", rx_data, 8'h5A);
    check("after_ferr_rdy", rdy, 1'b1);
    check("after_ferr_frm_err", frm_err, 1'b0);
    bit_out(1'b1, BD);

    // Short glitch must not disturb anything
    bit_out(1'b0, 4);
    bit_out(1'b1, 2 * BD);
    check("glitch_rdy", rdy, 1'b1);
    check("glitch_rx_data", rx_data, 8'h5A);
    check("glitch_frm_err", frm_err, 1'b0);
    check("glitch_overrun", overrun, 1'b0);

    // Reset during data bit 4 of 0x77; frame abandoned
    b = 8'h77;
    bit_out(1'b0, BD);
    for (int i = 0; i < 4; i++) bit_out(b[i], BD);
    bit_out(b[4], BD / 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rdy", rdy, 1'b0);
    check("midrst_frm_err", frm_err, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    bit_out(1'b1, 3 * BD);
    send_byte(8'h81, 1'b1);
    check("post_rst_rx_data", rx_data, 8'h81);
    check("post_rst_rdy", rdy, 1'b1);
    check("post_rst_overrun", overrun, 1'b0);
    pulse_clr();

    // Directed pattern bytes plus random traffic with acknowledge between frames
    for (int n = 0; n < 24; n++) begin
      case (n)
        0: b = 8'h00;
        1: b = 8'h55;
        2: b = 8'hAA;
        3: b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b, 1'b1);
      check($sformatf("stream_%0d_data", n), rx_data, b);
      check($sformatf("stream_%0d_rdy", n), rdy, 1'b1);
      check($sformatf("stream_%0d_frm_err", n), frm_err, 1'b0);
      check($sformatf("stream_%0d_overrun", n), overrun, 1'b0);
      pulse_clr();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
